// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_mc
// Description : Stall/flush controller for the 5-stage MIPS pipeline, covering
//               ID-resolved branch/jr hazards, load-use, MDU busy and precise
//               interrupt entry, plus a saturating stall-cycle counter.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl_mc #(
  parameter int unsigned AW       = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned EPC_REG  = 26,
  parameter int unsigned MDU_LAT  = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             interrupt,
  input  logic [AW-1:0]    rs_id,
  input  logic [AW-1:0]    rt_id,
  input  logic             branch_id,
  input  logic             jr_id,
  input  logic [2:0]       pcsrc_id,
  input  logic             mdu_start_id,
  input  logic             mdu_read_id,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic [AW-1:0]    wa_ex,
  input  logic [AW-1:0]    rt_ex,
  input  logic             regwrite_mem,
  input  logic             memread_mem,
  input  logic [AW-1:0]    wa_mem,
  input  logic [1:0]       memtoreg_mem,
  output logic             stall,
  output logic             flush,
  output logic             int_take,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned       c_MDU_W    = $clog2(MDU_LAT);
  localparam logic [c_MDU_W-1:0] c_MDU_LOAD = c_MDU_W'(MDU_LAT - 1);
  localparam logic [c_MDU_W-1:0] c_MDU_ONE  = c_MDU_W'(1);
  localparam logic [AW-1:0]      c_LINK     = AW'(LINK_REG);
  localparam logic [AW-1:0]      c_EPC      = AW'(EPC_REG);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_PEND = 2'd1;
  localparam logic [1:0] c_S_TAKE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [c_MDU_W-1:0] mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic w_int_take;
  logic w_mdu_busy;
  logic w_haz;
  logic w_stall;
  logic w_unused_regwrite_mem;

  // Register 0 is hardwired, so a write to it can never create a hazard.
  function automatic logic f_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_imp_rs, w_imp_rt, w_lu;

  assign w_ex_rs  = regwrite_ex & f_match(wa_ex, rs_id);
  assign w_ex_rt  = regwrite_ex & f_match(wa_ex, rt_id);
  assign w_mem_rs = memread_mem & f_match(wa_mem, rs_id);
  assign w_mem_rt = memread_mem & f_match(wa_mem, rt_id);
  assign w_imp_rs = ((memtoreg_mem == 2'b10) & f_match(c_LINK, rs_id)) |
                    ((memtoreg_mem == 2'b11) & f_match(c_EPC, rs_id));
  assign w_imp_rt = ((memtoreg_mem == 2'b10) & f_match(c_LINK, rt_id)) |
                    ((memtoreg_mem == 2'b11) & f_match(c_EPC, rt_id));
  assign w_lu     = memread_ex & (f_match(rt_ex, rs_id) | f_match(rt_ex, rt_id));

  assign w_mdu_busy = (mdu_cnt_q != '0);

  assign w_haz = w_lu
               | (branch_id & (w_ex_rs | w_ex_rt | w_mem_rs | w_mem_rt | w_imp_rs | w_imp_rt))
               | (jr_id & (w_ex_rs | w_mem_rs | w_imp_rs))
               | ((mdu_read_id | mdu_start_id) & w_mdu_busy);

  // Interrupt entry overrides any hazard so the handler redirect is never held.
  assign w_stall = ~reset & ~w_int_take & w_haz;

  // Regwrite in MEM is resolved by forwarding; only loads/implicit writes stall.
  assign w_unused_regwrite_mem = regwrite_mem;

  // ---------------- interrupt FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= c_S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: if (interrupt) state_d = c_S_PEND;
      c_S_PEND: if (!w_stall && !w_mdu_busy) state_d = c_S_TAKE;
      c_S_TAKE: state_d = interrupt ? c_S_PEND : c_S_IDLE;
      default:  state_d = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_int_take = (state_q == c_S_TAKE);
  end

  // ---------------- MDU busy counter ----------------
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (mdu_start_id && !w_stall && !w_int_take) mdu_cnt_d = c_MDU_LOAD;
    else if (w_mdu_busy)                         mdu_cnt_d = mdu_cnt_q - c_MDU_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mdu_cnt_q <= '0;
    else       mdu_cnt_q <= mdu_cnt_d;
  end

  // ---------------- stall performance counter ----------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != c_CNT_MAX)) stall_cnt_d = stall_cnt_q + c_CNT_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall     = w_stall;
  assign flush     = ~reset & (w_int_take | (~w_stall & (pcsrc_id != 3'd0)));
  assign int_take  = w_int_take;
  assign mdu_busy  = w_mdu_busy;
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_mc
// Description : Directed bench for hazard_ctrl_mc with a register-mask model.
// Revision    : 1.0
// ============================================================================
module tb_hazard_ctrl_mc;

  localparam int unsigned AW      = 5;
  localparam int unsigned MDU_LAT = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, interrupt;
  logic [AW-1:0] rs_id, rt_id, wa_ex, rt_ex, wa_mem;
  logic branch_id, jr_id, mdu_start_id, mdu_read_id;
  logic [2:0] pcsrc_id;
  logic regwrite_ex, memread_ex, regwrite_mem, memread_mem;
  logic [1:0] memtoreg_mem;
  logic stall, flush, int_take, mdu_busy;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // model state: remaining MDU cycles, pending/taking interrupt, stall count
  int m_rem  = 0;
  bit m_pend = 1'b0;
  bit m_take = 1'b0;
  int m_cnt  = 0;

  hazard_ctrl_mc #(.AW(AW), .LINK_REG(31), .EPC_REG(26), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .rs_id(rs_id), .rt_id(rt_id), .branch_id(branch_id), .jr_id(jr_id),
    .pcsrc_id(pcsrc_id), .mdu_start_id(mdu_start_id), .mdu_read_id(mdu_read_id),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .wa_ex(wa_ex), .rt_ex(rt_ex),
    .regwrite_mem(regwrite_mem), .memread_mem(memread_mem), .wa_mem(wa_mem),
    .memtoreg_mem(memtoreg_mem),
    .stall(stall), .flush(flush), .int_take(int_take), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Registers whose new value is not yet visible to an ID-stage comparator,
  // and registers being loaded by the instruction right ahead of ID.
  function automatic bit f_haz();
    bit [31:0] late;
    bit [31:0] loading;
    late = '0;
    loading = '0;
    if (regwrite_ex)           late[wa_ex]  = 1'b1;
    if (memread_mem)           late[wa_mem] = 1'b1;
    if (memtoreg_mem == 2'b10) late[31]     = 1'b1;
    if (memtoreg_mem == 2'b11) late[26]     = 1'b1;
    if (memread_ex)            loading[rt_ex] = 1'b1;
    late[0] = 1'b0;
    loading[0] = 1'b0;
    return loading[rs_id] || loading[rt_id]
        || (branch_id && (late[rs_id] || late[rt_id]))
        || (jr_id && late[rs_id])
        || ((mdu_read_id || mdu_start_id) && (m_rem > 0));
  endfunction

  function automatic bit e_stall();
    return !reset && !m_take && f_haz();
  endfunction

  function automatic bit e_flush();
    return !reset && (m_take || (!e_stall() && pcsrc_id != 3'd0));
  endfunction

  always @(posedge reset) begin
    m_rem = 0; m_pend = 0; m_take = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_pend = 0; m_take = 0; m_cnt = 0;
    end else begin
      bit s, busy;
      s = e_stall();
      busy = (m_rem > 0);
      if (s && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (mdu_start_id && !s && !m_take) m_rem = MDU_LAT - 1;
      else if (m_rem > 0)                m_rem = m_rem - 1;
      if (m_take) begin
        m_take = 1'b0;
        m_pend = interrupt;
      end else if (m_pend) begin
        if (!s && !busy) begin
          m_take = 1'b1;
          m_pend = 1'b0;
        end
      end else if (interrupt) begin
        m_pend = 1'b1;
      end
    end
  end

  // Every-cycle compare against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      chk("stall",     32'(stall),     32'(e_stall()));
      chk("flush",     32'(flush),     32'(e_flush()));
      chk("int_take",  32'(int_take),  32'(m_take));
      chk("mdu_busy",  32'(mdu_busy),  32'(m_rem > 0));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs_id = '0; rt_id = '0; wa_ex = '0; rt_ex = '0; wa_mem = '0;
    branch_id = 0; jr_id = 0; pcsrc_id = '0; mdu_start_id = 0; mdu_read_id = 0;
    regwrite_ex = 0; memread_ex = 0; regwrite_mem = 0; memread_mem = 0;
    memtoreg_mem = 2'b00;
  endtask

  task automatic lw_hazard();
    memread_ex = 1; rt_ex = 5'd5; rs_id = 5'd5;
  endtask

  initial begin
    reset = 1'b1;
    interrupt = 1'b0;
    idle_in();
    repeat (2) tick();
    lw_hazard(); pcsrc_id = 3'd1;
    #1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    idle_in();
    reset = 1'b0;
    check_en = 1'b1;
    #1;
    chk("rst_cnt",  32'(stall_cnt), 0);
    chk("rst_busy", 32'(mdu_busy),  0);
    chk("rst_take", 32'(int_take),  0);
    tick();

    // load-use
    lw_hazard(); #1;
    chk("lu_stall", 32'(stall), 1);
    chk("lu_flush", 32'(flush), 0);
    tick();
    chk("lu_cnt", 32'(stall_cnt), 1);
    rt_ex = 5'd0; #1;
    chk("lu_r0", 32'(stall), 0);
    tick(); idle_in();

    // beq vs jal link in MEM, then redirect once clear
    branch_id = 1; rs_id = 5'd31; rt_id = 5'd4; memtoreg_mem = 2'b10; pcsrc_id = 3'd1; #1;
    chk("beq_link_stall", 32'(stall), 1);
    chk("beq_link_flush", 32'(flush), 0);
    tick();
    memtoreg_mem = 2'b00; #1;
    chk("beq_go_stall", 32'(stall), 0);
    chk("beq_go_flush", 32'(flush), 1);
    tick(); idle_in();

    branch_id = 1; rt_id = 5'd26; memtoreg_mem = 2'b11; #1;
    chk("beq_epc", 32'(stall), 1);
    tick(); idle_in();

    jr_id = 1; rs_id = 5'd3; rt_id = 5'd7; regwrite_ex = 1; wa_ex = 5'd7; #1;
    chk("jr_rt_only", 32'(stall), 0);
    tick();
    rs_id = 5'd7; #1;
    chk("jr_rs_ex", 32'(stall), 1);
    tick(); idle_in();

    branch_id = 1; rt_id = 5'd9; memread_mem = 1; wa_mem = 5'd9; #1;
    chk("beq_memload", 32'(stall), 1);
    tick();
    memread_mem = 0; regwrite_mem = 1; #1;
    chk("beq_memalu", 32'(stall), 0);
    tick(); idle_in();

    // MDU: mult at T, mflo stalls T+1..T+3, proceeds at T+4
    mdu_start_id = 1; #1;
    chk("mult_issue", 32'(stall), 0);
    tick(); idle_in();
    mdu_read_id = 1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("mflo_busy", 32'(mdu_busy), 1);
      chk("mflo_stall", 32'(stall), 1);
      tick();
    end
    #1;
    chk("mflo_go", 32'(stall), 0);
    chk("mflo_idle", 32'(mdu_busy), 0);
    chk("mdu_cnt", 32'(stall_cnt), 8);
    tick(); idle_in();

    // interrupt pulse while MDU busy
    mdu_start_id = 1; tick(); idle_in();
    interrupt = 1; tick(); interrupt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pend_hold", 32'(int_take), 0);
      tick();
    end
    lw_hazard(); pcsrc_id = 3'd2; #1;
    chk("take_pulse", 32'(int_take), 1);
    chk("take_flush", 32'(flush), 1);
    chk("take_nostall", 32'(stall), 0);
    tick(); idle_in(); #1;
    chk("take_end", 32'(int_take), 0);
    tick();

    // held interrupt re-enters PEND; a stall holds PEND; no MDU issue during TAKE
    interrupt = 1; tick(); tick(); #1;
    chk("take2", 32'(int_take), 1);
    tick(); interrupt = 0; lw_hazard(); #1;
    chk("pend_stall_take", 32'(int_take), 0);
    chk("pend_stall", 32'(stall), 1);
    tick(); idle_in(); #1;
    chk("pend_clear", 32'(int_take), 0);
    tick(); mdu_start_id = 1; #1;
    chk("take3", 32'(int_take), 1);
    tick(); idle_in(); #1;
    chk("take3_end", 32'(int_take), 0);
    chk("no_mdu_on_take", 32'(mdu_busy), 0);
    tick();

    // saturation
    lw_hazard();
    repeat ((1 << CNT_W) + 5) tick();
    chk("cnt_sat", 32'(stall_cnt), CNT_MAX);
    chk("sat_stall", 32'(stall), 1);
    idle_in(); tick();

    // async reset mid-MDU with interrupt pending
    mdu_start_id = 1; tick(); idle_in();
    interrupt = 1; tick(); interrupt = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(mdu_busy),  0);
    chk("arst_take", 32'(int_take),  0);
    chk("arst_cnt",  32'(stall_cnt), 0);
    chk("arst_stall", 32'(stall), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("arst_no_take", 32'(int_take), 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Next-generation pipeline stall/flush controller for the 5-stage MIPS core. Sits beside the ID stage.
- Detects data hazards for ID-resolved branches and jumps, and for load-use. Stalls on the multi-cycle mul/div unit (MDU) using an internal busy counter.
- Sequences precise interrupt entry with a small state machine.
- Maintains a saturating stall-cycle performance counter.

Parameters:
- AW, 5: register-address width.
- LINK_REG, 31: register implicitly written when memtoreg_mem==2'b10 (jal link).
- EPC_REG, 26: register implicitly written when memtoreg_mem==2'b11.
- MDU_LAT, 32: MDU latency in cycles; must be >=2.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- interrupt  in  1  external interrupt request (level, sampled each cycle).
- rs_id, rt_id  in  AW each  source registers of the ID instruction.
- branch_id  in  1  ID instruction is a conditional branch (reads rs and rt).
- jr_id  in  1  ID instruction is jr/jalr (reads rs).
- pcsrc_id  in  3  nonzero when ID redirects the PC.
- mdu_start_id  in  1  ID instruction is mult/div.
- mdu_read_id  in  1  ID instruction is mfhi/mflo.
- regwrite_ex, memread_ex  in  1 each  EX-stage control.
- wa_ex, rt_ex  in  AW each  EX destination register / EX rt.
- regwrite_mem, memread_mem  in  1 each  MEM-stage control.
- wa_mem  in  AW  MEM destination register.
- memtoreg_mem  in  2  MEM writeback select.
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
- flush  out  1  squash IF/ID.
- int_take  out  1  one-cycle pulse: redirect to handler, save EPC.
- mdu_busy  out  1  MDU result not yet available.
- stall_cnt  out  CNT_W  cycles with stall==1.

Behaviour:
- Reset (async) clears: MDU counter, FSM state (IDLE) and stall_cnt. All outputs are 0 while reset is high.
- Hazard terms (combinational). Register 0 never matches. stall is the OR of:
  - Load-use: memread_ex, rt_ex matches rs_id or rt_id.
  - Branch vs EX: branch_id, regwrite_ex, wa_ex matches rs_id or rt_id.
  - Branch vs MEM load: branch_id, memread_mem, wa_mem matches rs_id or rt_id.
  - Branch vs implicit write: branch_id, memtoreg_mem==2'b10 with LINK_REG matching rs_id or rt_id; likewise 2'b11 with EPC_REG.
  - jr vs EX/MEM: the same EX, MEM-load and implicit-write terms with jr_id, comparing rs_id only.
  - MDU: (mdu_read_id | mdu_start_id) & mdu_busy.
- MDU counter (width clog2(MDU_LAT)):
  - Loaded with MDU_LAT-1 on accepted issue: mdu_start_id & !stall & !int_take.
  - Otherwise decrements when nonzero.
  - mdu_busy = (counter != 0).
  - mfhi issued exactly when counter reaches 0 proceeds without stall.
- Interrupt FSM:
  - IDLE -> PEND when interrupt==1.
  - PEND -> TAKE when stall==0 and mdu_busy==0; otherwise stays in PEND.
  - TAKE lasts exactly one cycle, with int_take=1.
  - TAKE -> PEND if interrupt is still 1, else -> IDLE.
  - Further interrupt assertions in PEND are absorbed (no queueing).
- flush = int_take | (!stall & (pcsrc_id != 0)).
  - Stall has priority over a PC redirect; int_take has priority over everything.
  - stall is forced to 0 in the TAKE cycle, and a PC redirect in that cycle is discarded.
- stall_cnt increments by 1 each cycle stall==1 and saturates at all-ones (no wrap).
- Latency:
  - stall and flush are combinational from the same cycle's inputs.
  - int_take comes at the earliest 1 cycle after interrupt is sampled.
- Reset mid-operation: MDU busy and a pending interrupt are both discarded immediately.

Test Plan:
- lw $5 in EX (memread_ex=1, rt_ex=5), ID add reads rs=5 -> stall=1, flush=0, stall_cnt +1. Same stimulus with rt_ex=0 -> stall=0.
- ID beq reads $31, MEM memtoreg=2'b10, pcsrc_id=1 -> stall=1, flush=0. Next cycle, hazard gone and pcsrc_id=1 -> stall=0, flush=1.
- mult issued at cycle T with MDU_LAT=4 -> mdu_busy=1 for T+1..T+3. mflo in ID during T+1..T+3 -> stall=1; at T+4 -> stall=0.
- Interrupt pulse while mdu_busy=1 -> FSM holds PEND, int_take=0. First cycle with counter 0 and no stall -> int_take=1 and flush=1 for one cycle; pcsrc_id=2 in that cycle ignored.
- Force stall for 2^CNT_W+5 cycles with CNT_W=4 -> stall_cnt stops at 15.
- Assert reset asynchronously mid-MDU with an interrupt pending -> mdu_busy, int_take and stall_cnt are 0 immediately, before the next clk edge.
